// File: rtl/pipe_ctrl_stage.sv
// pipe_ctrl_stage
//   Carries the main decoder's control bundle plus rd/rs1/rs2 through the
//   ID/EX, EX/MEM and MEM/WB registers of a five-stage pipeline. Detects
//   load-use hazards (multi-cycle stall), handles an EX-resolved redirect
//   flush and a global data-memory freeze, and produces EX forwarding selects.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   id_valid, id_ctrl             ID occupancy and decoded control bundle
//   id_rs1, id_rs2, id_rd         ID register fields
//   ex_redirect                   branch/jump resolved taken in EX
//   mem_stall                     data memory busy, freezes the pipe
//   stall_if_id, flush_if_id      IF/ID hold / bubble requests (combinational)
//   ex_/mem_/wb_valid,_ctrl,_rd   per-stage occupancy, bundle, destination
//   wb_regwrite                   register-file write enable
//   fwd_a, fwd_b                  EX operand source: 00 RF, 10 EX/MEM, 01 MEM/WB
module pipe_ctrl_stage #(
  parameter int CTRL_W         = 11,
  parameter int LOAD_USE_STALL = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic              ex_redirect,
  input  logic              mem_stall,
  output logic              stall_if_id,
  output logic              flush_if_id,
  output logic              ex_valid,
  output logic              mem_valid,
  output logic              wb_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CTRL_W-1:0] mem_ctrl,
  output logic [CTRL_W-1:0] wb_ctrl,
  output logic [4:0]        ex_rd,
  output logic [4:0]        mem_rd,
  output logic [4:0]        wb_rd,
  output logic              wb_regwrite,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  localparam logic [1:0] STALL_INIT = 2'(LOAD_USE_STALL - 1);
  localparam int         B_REGWR    = 8;
  localparam int         B_MEMRD    = 7;

  logic              r_ex_valid, r_mem_valid, r_wb_valid;
  logic [CTRL_W-1:0] r_ex_ctrl, r_mem_ctrl, r_wb_ctrl;
  logic [4:0]        r_ex_rd, r_mem_rd, r_wb_rd;
  logic [4:0]        r_ex_rs1, r_ex_rs2;
  logic [1:0]        r_stall_cnt;
  logic              r_wb_regwrite;
  logic [1:0]        r_fwd_a, r_fwd_b;

  logic              w_hz, w_redirect;
  logic              w_stall, w_flush, w_bubble;
  logic [1:0]        w_cnt_nxt;
  logic              w_ex_take;
  logic [CTRL_W-1:0] w_ex_ctrl_nxt;
  logic [4:0]        w_ex_rd_nxt, w_ex_rs1_nxt, w_ex_rs2_nxt;

  // Forward select for one source: the younger producer (EX/MEM) wins; x0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic m_wr, input logic [4:0] m_rd,
                                         input logic w_wr, input logic [4:0] w_rd);
    logic [1:0] sel;
    sel = 2'b00;
    if (m_wr && (m_rd != 5'd0) && (m_rd == src)) begin
      sel = 2'b10;
    end else if (w_wr && (w_rd != 5'd0) && (w_rd == src)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  assign w_hz = id_valid && r_ex_valid && r_ex_ctrl[B_MEMRD] && (r_ex_rd != 5'd0) &&
                ((r_ex_rd == id_rs1) || (r_ex_rd == id_rs2));
  assign w_redirect = ex_redirect && r_ex_valid && !mem_stall;

  // Hazard priority: memory freeze, then redirect, then an ongoing stall, then a new load-use.
  always_comb begin
    w_stall   = 1'b0;
    w_flush   = 1'b0;
    w_bubble  = 1'b0;
    w_cnt_nxt = r_stall_cnt;
    if (mem_stall) begin
      w_stall = 1'b1;
    end else if (w_redirect) begin
      w_flush   = 1'b1;
      w_bubble  = 1'b1;
      w_cnt_nxt = 2'd0;
    end else if (r_stall_cnt != 2'd0) begin
      w_stall   = 1'b1;
      w_bubble  = 1'b1;
      w_cnt_nxt = r_stall_cnt - 2'd1;
    end else if (w_hz) begin
      w_stall   = 1'b1;
      w_bubble  = 1'b1;
      w_cnt_nxt = STALL_INIT;
    end else begin
      w_stall = 1'b0;
    end
  end

  // Held low during reset so every output reads 0 while rst_n is asserted.
  assign stall_if_id = rst_n && w_stall;
  assign flush_if_id = rst_n && w_flush;

  // A bubble is fully zeroed so an empty stage can never match a register.
  assign w_ex_take     = id_valid && !w_bubble;
  assign w_ex_ctrl_nxt = w_ex_take ? id_ctrl : '0;
  assign w_ex_rd_nxt   = w_ex_take ? id_rd   : 5'd0;
  assign w_ex_rs1_nxt  = w_ex_take ? id_rs1  : 5'd0;
  assign w_ex_rs2_nxt  = w_ex_take ? id_rs2  : 5'd0;

  // Pipeline registers; forwarding selects and write enable are precomputed from next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid    <= 1'b0;
      r_mem_valid   <= 1'b0;
      r_wb_valid    <= 1'b0;
      r_ex_ctrl     <= '0;
      r_mem_ctrl    <= '0;
      r_wb_ctrl     <= '0;
      r_ex_rd       <= 5'd0;
      r_mem_rd      <= 5'd0;
      r_wb_rd       <= 5'd0;
      r_ex_rs1      <= 5'd0;
      r_ex_rs2      <= 5'd0;
      r_stall_cnt   <= 2'd0;
      r_wb_regwrite <= 1'b0;
      r_fwd_a       <= 2'b00;
      r_fwd_b       <= 2'b00;
    end else if (!mem_stall) begin
      r_ex_valid    <= w_ex_take;
      r_ex_ctrl     <= w_ex_ctrl_nxt;
      r_ex_rd       <= w_ex_rd_nxt;
      r_ex_rs1      <= w_ex_rs1_nxt;
      r_ex_rs2      <= w_ex_rs2_nxt;
      r_mem_valid   <= r_ex_valid;
      r_mem_ctrl    <= r_ex_ctrl;
      r_mem_rd      <= r_ex_rd;
      r_wb_valid    <= r_mem_valid;
      r_wb_ctrl     <= r_mem_ctrl;
      r_wb_rd       <= r_mem_rd;
      r_stall_cnt   <= w_cnt_nxt;
      r_wb_regwrite <= r_mem_valid && r_mem_ctrl[B_REGWR];
      r_fwd_a       <= fwd_sel(w_ex_rs1_nxt, r_ex_valid && r_ex_ctrl[B_REGWR], r_ex_rd,
                               r_mem_valid && r_mem_ctrl[B_REGWR], r_mem_rd);
      r_fwd_b       <= fwd_sel(w_ex_rs2_nxt, r_ex_valid && r_ex_ctrl[B_REGWR], r_ex_rd,
                               r_mem_valid && r_mem_ctrl[B_REGWR], r_mem_rd);
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  assign ex_valid    = r_ex_valid;
  assign mem_valid   = r_mem_valid;
  assign wb_valid    = r_wb_valid;
  assign ex_ctrl     = r_ex_ctrl;
  assign mem_ctrl    = r_mem_ctrl;
  assign wb_ctrl     = r_wb_ctrl;
  assign ex_rd       = r_ex_rd;
  assign mem_rd      = r_mem_rd;
  assign wb_rd       = r_wb_rd;
  assign wb_regwrite = r_wb_regwrite;
  assign fwd_a       = r_fwd_a;
  assign fwd_b       = r_fwd_b;

endmodule

// File: tb/tb_pipe_ctrl_stage.sv
module tb_pipe_ctrl_stage;

  localparam logic [10:0] C_RTYPE = 11'b00100100000;
  localparam logic [10:0] C_ADDI  = 11'b10100110000;
  localparam logic [10:0] C_LW    = 11'b11110000000;
  localparam logic [10:0] C_BEQ   = 11'b00000011000;

  typedef struct packed {
    logic        stall, flush, exv, memv, wbv;
    logic [10:0] exc, memc, wbc;
    logic [4:0]  exr, memr, wbr;
    logic        wbrw;
    logic [1:0]  fa, fb;
  } obs_t;

  typedef struct {
    bit        v;
    bit [10:0] c;
    bit [4:0]  rd, rs1, rs2;
  } stg_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, ex_redirect, mem_stall;
  logic [10:0] id_ctrl;
  logic [4:0]  id_rs1, id_rs2, id_rd;

  logic        s1_stall, s1_flush, s1_exv, s1_memv, s1_wbv, s1_wbrw;
  logic [10:0] s1_exc, s1_memc, s1_wbc;
  logic [4:0]  s1_exr, s1_memr, s1_wbr;
  logic [1:0]  s1_fa, s1_fb;
  logic        s3_stall, s3_flush, s3_exv, s3_memv, s3_wbv, s3_wbrw;
  logic [10:0] s3_exc, s3_memc, s3_wbc;
  logic [4:0]  s3_exr, s3_memr, s3_wbr;
  logic [1:0]  s3_fa, s3_fb;
  obs_t        o1, o3;

  int total = 0;
  int bad   = 0;
  int stall_seen [2];

  // reference model: index 0 -> LOAD_USE_STALL=1, index 1 -> LOAD_USE_STALL=3
  stg_t pipe [2][3];
  int   cnt  [2];
  int   lus  [2] = '{1, 3};

  always #5 clk = ~clk;

  pipe_ctrl_stage #(.CTRL_W(11), .LOAD_USE_STALL(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .ex_redirect(ex_redirect), .mem_stall(mem_stall),
    .stall_if_id(s1_stall), .flush_if_id(s1_flush),
    .ex_valid(s1_exv), .mem_valid(s1_memv), .wb_valid(s1_wbv),
    .ex_ctrl(s1_exc), .mem_ctrl(s1_memc), .wb_ctrl(s1_wbc),
    .ex_rd(s1_exr), .mem_rd(s1_memr), .wb_rd(s1_wbr),
    .wb_regwrite(s1_wbrw), .fwd_a(s1_fa), .fwd_b(s1_fb));

  pipe_ctrl_stage #(.CTRL_W(11), .LOAD_USE_STALL(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .ex_redirect(ex_redirect), .mem_stall(mem_stall),
    .stall_if_id(s3_stall), .flush_if_id(s3_flush),
    .ex_valid(s3_exv), .mem_valid(s3_memv), .wb_valid(s3_wbv),
    .ex_ctrl(s3_exc), .mem_ctrl(s3_memc), .wb_ctrl(s3_wbc),
    .ex_rd(s3_exr), .mem_rd(s3_memr), .wb_rd(s3_wbr),
    .wb_regwrite(s3_wbrw), .fwd_a(s3_fa), .fwd_b(s3_fb));

  assign o1 = {s1_stall, s1_flush, s1_exv, s1_memv, s1_wbv, s1_exc, s1_memc, s1_wbc,
               s1_exr, s1_memr, s1_wbr, s1_wbrw, s1_fa, s1_fb};
  assign o3 = {s3_stall, s3_flush, s3_exv, s3_memv, s3_wbv, s3_exc, s3_memc, s3_wbc,
               s3_exr, s3_memr, s3_wbr, s3_wbrw, s3_fa, s3_fb};

  function automatic obs_t get_obs(int k);
    return (k == 0) ? o1 : o3;
  endfunction

  // A load sitting in EX whose destination is read by the instruction in ID.
  function automatic bit m_hz(int k);
    stg_t e;
    e = pipe[k][0];
    return id_valid && e.v && e.c[7] && (e.rd != 5'd0) && (e.rd == id_rs1 || e.rd == id_rs2);
  endfunction

  function automatic bit m_redir(int k);
    return ex_redirect && pipe[k][0].v && !mem_stall;
  endfunction

  function automatic bit [1:0] m_fwd(int k, bit [4:0] src);
    if (src == 5'd0) return 2'b00;
    if (pipe[k][1].v && pipe[k][1].c[8] && pipe[k][1].rd == src) return 2'b10;
    if (pipe[k][2].v && pipe[k][2].c[8] && pipe[k][2].rd == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic obs_t m_expect(int k);
    obs_t e;
    e = '0;
    if (rst_n) begin
      e.flush = m_redir(k);
      e.stall = mem_stall || (!m_redir(k) && (cnt[k] != 0 || m_hz(k)));
    end
    e.exv  = pipe[k][0].v;  e.exc  = pipe[k][0].c;  e.exr  = pipe[k][0].rd;
    e.memv = pipe[k][1].v;  e.memc = pipe[k][1].c;  e.memr = pipe[k][1].rd;
    e.wbv  = pipe[k][2].v;  e.wbc  = pipe[k][2].c;  e.wbr  = pipe[k][2].rd;
    e.wbrw = pipe[k][2].v && pipe[k][2].c[8];
    e.fa   = m_fwd(k, pipe[k][0].rs1);
    e.fb   = m_fwd(k, pipe[k][0].rs2);
    return e;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < 3; s++) pipe[k][s] = '{default: 0};
      cnt[k] = 0;
    end
  endtask

  task automatic m_clock();
    stg_t nw;
    bit   rd_now, hz_now;
    if (!rst_n) begin
      m_reset();
    end else if (!mem_stall) begin
      for (int k = 0; k < 2; k++) begin
        rd_now = m_redir(k);
        hz_now = m_hz(k);
        nw = '{default: 0};
        if (!rd_now && cnt[k] == 0 && !hz_now && id_valid)
          nw = '{v: 1'b1, c: id_ctrl, rd: id_rd, rs1: id_rs1, rs2: id_rs2};
        if (rd_now)           cnt[k] = 0;
        else if (cnt[k] != 0) cnt[k] = cnt[k] - 1;
        else if (hz_now)      cnt[k] = lus[k] - 1;
        pipe[k][2] = pipe[k][1];
        pipe[k][1] = pipe[k][0];
        pipe[k][0] = nw;
      end
    end
  endtask

  task automatic chk(string tag, int k, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s[lus=%0d] observed=%0h expected=%0h", tag, lus[k], obs, exp);
    end
  endtask

  task automatic check_all();
    obs_t g, e;
    for (int k = 0; k < 2; k++) begin
      g = get_obs(k);
      e = m_expect(k);
      chk("stall_if_id", k, 32'(g.stall), 32'(e.stall));
      chk("flush_if_id", k, 32'(g.flush), 32'(e.flush));
      chk("ex_valid",    k, 32'(g.exv),   32'(e.exv));
      chk("mem_valid",   k, 32'(g.memv),  32'(e.memv));
      chk("wb_valid",    k, 32'(g.wbv),   32'(e.wbv));
      chk("ex_ctrl",     k, 32'(g.exc),   32'(e.exc));
      chk("mem_ctrl",    k, 32'(g.memc),  32'(e.memc));
      chk("wb_ctrl",     k, 32'(g.wbc),   32'(e.wbc));
      chk("ex_rd",       k, 32'(g.exr),   32'(e.exr));
      chk("mem_rd",      k, 32'(g.memr),  32'(e.memr));
      chk("wb_rd",       k, 32'(g.wbr),   32'(e.wbr));
      chk("wb_regwrite", k, 32'(g.wbrw),  32'(e.wbrw));
      chk("fwd_a",       k, 32'(g.fa),    32'(e.fa));
      chk("fwd_b",       k, 32'(g.fb),    32'(e.fb));
    end
  endtask

  // Inputs are already set; check mid-cycle, clock, advance the model, settle.
  task automatic step();
    #1;
    check_all();
    if (o1.stall) stall_seen[0]++;
    if (o3.stall) stall_seen[1]++;
    @(posedge clk);
    m_clock();
    #2;
  endtask

  task automatic issue(logic v, logic [10:0] c, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd);
    id_valid = v; id_ctrl = c; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    step();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) issue(1'b0, 11'd0, 5'd0, 5'd0, 5'd0);
  endtask

  initial begin
    rst_n = 1'b0; id_valid = 1'b0; id_ctrl = 11'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    id_rd = 5'd0; ex_redirect = 1'b0; mem_stall = 1'b0;
    m_reset();
    #2;
    step(); step();
    rst_n = 1'b1;
    idle(2);

    // back-to-back R-type: add x3 ; sub x5,x3,x4 ; and x8,x3,x9
    issue(1'b1, C_RTYPE, 5'd1, 5'd2, 5'd3);
    issue(1'b1, C_RTYPE, 5'd3, 5'd4, 5'd5);
    chk("rtype_fwd_a_mem", 0, 32'(s1_fa), 32'(2'b10));
    chk("rtype_no_stall",  0, 32'(stall_seen[0]), 32'd0);
    issue(1'b1, C_RTYPE, 5'd3, 5'd9, 5'd8);
    chk("rtype_fwd_a_wb",  0, 32'(s1_fa), 32'(2'b01));
    idle(3);

    // load-use: lw x6 ; add x7,x6,x1 held in ID until both instances accept it
    stall_seen[0] = 0; stall_seen[1] = 0;
    issue(1'b1, C_LW, 5'd2, 5'd0, 5'd6);
    issue(1'b1, C_RTYPE, 5'd6, 5'd1, 5'd7);
    issue(1'b1, C_RTYPE, 5'd6, 5'd1, 5'd7);
    chk("lu1_fwd_a", 0, 32'(s1_fa), 32'(2'b01));
    issue(1'b1, C_RTYPE, 5'd6, 5'd1, 5'd7);
    issue(1'b1, C_RTYPE, 5'd6, 5'd1, 5'd7);
    chk("lu3_fwd_a", 1, 32'(s3_fa), 32'(2'b00));
    chk("lu3_ex_rd", 1, 32'(s3_exr), 32'd7);
    chk("lu1_stall_cycles", 0, 32'(stall_seen[0]), 32'd1);
    chk("lu3_stall_cycles", 1, 32'(stall_seen[1]), 32'd3);
    idle(3);

    // async reset while the LOAD_USE_STALL=3 instance has one stall cycle left
    issue(1'b1, C_LW, 5'd2, 5'd0, 5'd6);
    issue(1'b1, C_RTYPE, 5'd1, 5'd6, 5'd7);
    issue(1'b1, C_RTYPE, 5'd1, 5'd6, 5'd7);
    rst_n = 1'b0;
    m_reset();
    #1;
    check_all();
    chk("rst_async_stall", 1, 32'(s3_stall), 32'd0);
    chk("rst_async_mem_v", 1, 32'(s3_memv), 32'd0);
    id_valid = 1'b0;
    step();
    rst_n = 1'b1;
    idle(3);
    chk("rst_empty_wb", 1, 32'(s3_wbv), 32'd0);

    // redirect while ID holds a load-use hazard on the instruction in EX
    issue(1'b1, C_LW | C_BEQ, 5'd2, 5'd0, 5'd6);
    ex_redirect = 1'b1;
    id_valid = 1'b1; id_ctrl = C_RTYPE; id_rs1 = 5'd6; id_rs2 = 5'd1; id_rd = 5'd7;
    #1;
    chk("redir_flush", 0, 32'(s1_flush), 32'd1);
    chk("redir_stall", 1, 32'(s3_stall), 32'd0);
    step();
    ex_redirect = 1'b0;
    chk("redir_ex_bubble", 1, 32'(s3_exv), 32'd0);
    idle(2);

    // memory freeze for 4 cycles mid-stream, with a redirect pending at the end
    issue(1'b1, C_ADDI, 5'd1, 5'd0, 5'd10);
    issue(1'b1, C_RTYPE, 5'd10, 5'd10, 5'd11);
    issue(1'b1, C_BEQ, 5'd11, 5'd10, 5'd0);
    mem_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ex_redirect = (i == 3);
      issue(1'b1, C_RTYPE, 5'd11, 5'd10, 5'd12);
      chk("mstall_hold_ex", 0, 32'(s1_exc), 32'(C_BEQ));
    end
    mem_stall = 1'b0;
    ex_redirect = 1'b1;
    #1;
    chk("mstall_release_flush", 0, 32'(s1_flush), 32'd1);
    step();
    ex_redirect = 1'b0;
    idle(3);

    // x0 is never forwarded and never stalls
    stall_seen[0] = 0; stall_seen[1] = 0;
    issue(1'b1, C_ADDI, 5'd1, 5'd0, 5'd0);
    issue(1'b1, C_RTYPE, 5'd0, 5'd0, 5'd13);
    chk("x0_fwd_a", 0, 32'(s1_fa), 32'(2'b00));
    issue(1'b1, C_LW, 5'd1, 5'd0, 5'd0);
    issue(1'b1, C_RTYPE, 5'd0, 5'd0, 5'd14);
    chk("x0_fwd_b", 1, 32'(s3_fb), 32'(2'b00));
    chk("x0_no_stall", 1, 32'(stall_seen[1]), 32'd0);
    idle(3);

    // randomized traffic on a small register set to provoke hazards
    for (int i = 0; i < 300; i++) begin
      ex_redirect = ($urandom_range(0, 9) == 0);
      mem_stall   = ($urandom_range(0, 6) == 0);
      id_valid    = ($urandom_range(0, 3) != 0);
      id_ctrl     = ($urandom_range(0, 2) == 0) ? C_LW : 11'($urandom);
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      id_rd       = 5'($urandom_range(0, 3));
      step();
    end
    ex_redirect = 1'b0;
    mem_stall = 1'b0;
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_stage.md
Name: pipe_ctrl_stage

Overview:
- Consumer end of the main decoder's 11-bit control bundle.
- Carries the bundle, rd and source register fields through the ID/EX, EX/MEM and MEM/WB registers of the five-stage pipeline.
- Detects load-use hazards and applies stalls, bubbles, a redirect flush and a global memory freeze.
- Generates the EX-stage forwarding selects.

Parameters:
- CTRL_W, 11, control bundle width. Bit order {ALUSrc[10], MemtoReg[9], RegWrite[8], MemRead[7], MemWrite[6], ALUOp[5:4], Branch[3], JalrSel[2], RWSel[1:0]}.
- LOAD_USE_STALL, 1, load-use stall cycles. Legal range 1..3.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_ctrl  in  CTRL_W  decoded bundle from the main decoder.
- id_rs1, id_rs2, id_rd  in  5 each  ID register fields.
- ex_redirect  in  1  branch taken or JAL/JALR resolved in EX; only meaningful when ex_valid=1.
- mem_stall  in  1  data memory busy; freezes the whole pipe.
- stall_if_id  out  1  hold PC and IF/ID.
- flush_if_id  out  1  replace IF/ID with a bubble.
- ex_valid, mem_valid, wb_valid  out  1 each  stage occupancy.
- ex_ctrl, mem_ctrl, wb_ctrl  out  CTRL_W each  per-stage bundle.
- ex_rd, mem_rd, wb_rd  out  5 each  per-stage destination register.
- wb_regwrite  out  1  register-file write enable; = wb_valid & wb_ctrl[8].
- fwd_a, fwd_b  out  2 each  EX operand source: 00 register file, 10 EX/MEM, 01 MEM/WB.

Behaviour:
- Reset (async, rst_n=0):
  - All valids, ctrl, rd, internal ex_rs1/ex_rs2 and stall_cnt clear to 0.
  - All outputs read 0.
  - Reset mid-stall aborts the stall immediately.
- Bubble: valid=0 with ctrl=0 and rd=0. Any stage with valid=0 is inert for hazards, forwarding and writes.
- Normal advance (mem_stall=0, no hazard, no redirect):
  - ID→EX takes id_valid, id_ctrl, id_rd, id_rs1, id_rs2.
  - EX→MEM and MEM→WB copy the stage contents.
  - Latency ID to WB is 3 cycles.
- Load-use detect, combinational:
  - hz = id_valid & ex_valid & ex_ctrl[7] & (ex_rd≠0) & (ex_rd==id_rs1 | ex_rd==id_rs2).
  - A store's rs2 counts as a source.
- stall_cnt (2 bits):
  - If stall_cnt=0 and hz: stall_if_id=1, a bubble enters EX, and stall_cnt loads LOAD_USE_STALL-1.
  - If stall_cnt≠0: stall_if_id=1, a bubble enters EX, and stall_cnt decrements.
  - EX→MEM→WB keeps advancing in both cases.
- Redirect (ex_redirect & ex_valid & !mem_stall):
  - flush_if_id=1, stall_if_id=0.
  - A bubble enters EX; the ID instruction is discarded.
  - stall_cnt forced to 0.
  - Takes priority over hz.
- mem_stall=1:
  - Every pipeline register and stall_cnt holds.
  - stall_if_id=1, flush_if_id=0.
  - wb_regwrite is still driven from current WB contents; the register-file write repeats harmlessly.
  - A redirect is acted on in the first cycle mem_stall=0.
- Forwarding (operand A uses ex_rs1, operand B uses ex_rs2):
  - 10 if mem_valid & mem_ctrl[8] & mem_rd≠0 & mem_rd==src.
  - Else 01 if wb_valid & wb_ctrl[8] & wb_rd≠0 & wb_rd==src.
  - Else 00.
  - MEM has priority over WB. x0 is never forwarded.
- stall_if_id and flush_if_id are combinational from current state and inputs. Everything else is registered.

Test Plan:
- Reset: assert rst_n=0 mid-stream while stall_cnt=1 → all outputs 0 asynchronously; after release with id_valid=0, pipe stays empty.
- Back-to-back R-type: add x3 then sub x5,x3,x4 → no stall; for sub in EX, fwd_a=10. A third instruction reading x3 two slots behind gets fwd_a=01.
- Load-use: lw x6 then add x7,x6,x1 with LOAD_USE_STALL=1 → stall_if_id=1 for exactly 1 cycle and a bubble in EX; add in EX sees fwd_a=01. Rerun with LOAD_USE_STALL=3 → stall_if_id=1 for 3 cycles; add then sees fwd_a=00.
- Redirect: beq valid in EX with ex_redirect=1 while ID holds a load-use hazard → flush_if_id=1, stall_if_id=0, next ex_valid=0, stall_cnt=0.
- mem_stall: hold mem_stall=1 for 4 cycles mid-stream → all stage regs unchanged and stall_if_id=1; pipe resumes correctly after release.
- x0 rule: addi x0 followed by a reader of x0, and lw x0 followed by a reader of x0 → fwd 00 and no stall.
